// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory model: a word-addressed array behind independent read and
// write channels, each serving one outstanding burst at a time.
module axi4_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int ID_WIDTH    = 8,
    parameter int DEPTH_WORDS = 1024,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_aw_valid,
    output logic                  mem_aw_ready,
    input  logic [ID_WIDTH-1:0]   mem_aw_bits_id,
    input  logic [ADDR_WIDTH-1:0] mem_aw_bits_addr,
    input  logic [7:0]            mem_aw_bits_len,
    input  logic [2:0]            mem_aw_bits_size,
    input  logic [1:0]            mem_aw_bits_burst,
    input  logic                  mem_aw_bits_lock,
    input  logic [3:0]            mem_aw_bits_cache,
    input  logic [2:0]            mem_aw_bits_prot,
    input  logic [3:0]            mem_aw_bits_qos,
    input  logic                  mem_w_valid,
    output logic                  mem_w_ready,
    input  logic [DATA_WIDTH-1:0] mem_w_bits_data,
    input  logic [STRB_WIDTH-1:0] mem_w_bits_strb,
    input  logic                  mem_w_bits_last,
    output logic                  mem_b_valid,
    input  logic                  mem_b_ready,
    output logic [ID_WIDTH-1:0]   mem_b_bits_id,
    output logic [1:0]            mem_b_bits_resp,
    input  logic                  mem_ar_valid,
    output logic                  mem_ar_ready,
    input  logic [ID_WIDTH-1:0]   mem_ar_bits_id,
    input  logic [ADDR_WIDTH-1:0] mem_ar_bits_addr,
    input  logic [7:0]            mem_ar_bits_len,
    input  logic [2:0]            mem_ar_bits_size,
    input  logic [1:0]            mem_ar_bits_burst,
    input  logic                  mem_ar_bits_lock,
    input  logic [3:0]            mem_ar_bits_cache,
    input  logic [2:0]            mem_ar_bits_prot,
    input  logic [3:0]            mem_ar_bits_qos,
    output logic                  mem_r_valid,
    input  logic                  mem_r_ready,
    output logic [ID_WIDTH-1:0]   mem_r_bits_id,
    output logic [DATA_WIDTH-1:0] mem_r_bits_data,
    output logic [1:0]            mem_r_bits_resp,
    output logic                  mem_r_bits_last
);
    localparam int LSB         = $clog2(STRB_WIDTH);
    localparam int IDX_W       = $clog2(DEPTH_WORDS);
    localparam int MEM_BYTES_I = DEPTH_WORDS * STRB_WIDTH;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = MEM_BYTES_I[ADDR_WIDTH:0];
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'd1:    next_addr = a + step;
            2'd2:    next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a;
        endcase
    endfunction

    function automatic logic [1:0] beat_resp(input logic [ADDR_WIDTH-1:0] a,
        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'd2) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        if ({1'b0, a} >= MEM_BYTES)
            beat_resp = RESP_DECERR;
        else if (burst == 2'd3 || size > 3'(LSB) || bad_wrap)
            beat_resp = RESP_SLVERR;
        else
            beat_resp = RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = IDX_W'(a >> LSB);
    endfunction

    function automatic logic [1:0] max_resp(input logic [1:0] x, input logic [1:0] y);
        max_resp = (x > y) ? x : y;
    endfunction

    logic unused_sideband;
    assign unused_sideband = ^{mem_aw_bits_lock, mem_aw_bits_cache, mem_aw_bits_prot,
                               mem_aw_bits_qos, mem_ar_bits_lock, mem_ar_bits_cache,
                               mem_ar_bits_prot, mem_ar_bits_qos};

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst, w_acc, w_beat_resp, w_final_resp;
    logic                  w_fire, w_final, w_we;
    logic [DATA_WIDTH-1:0] w_merged;

    always_comb begin
        w_fire       = mem_w_ready && mem_w_valid;
        w_final      = (w_cnt == w_len);
        w_beat_resp  = beat_resp(w_addr, w_len, w_size, w_burst);
        w_we         = w_fire && (w_beat_resp == RESP_OKAY);
        // A misplaced or missing wlast is folded into the running response.
        w_final_resp = max_resp(max_resp(w_acc, w_beat_resp),
                                (mem_w_bits_last != w_final) ? RESP_SLVERR : RESP_OKAY);
        w_merged = mem[word_idx(w_addr)];
        for (int b = 0; b < STRB_WIDTH; b++)
            if (mem_w_bits_strb[b]) w_merged[b*8 +: 8] = mem_w_bits_data[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (w_we) mem[word_idx(w_addr)] <= w_merged;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state         <= W_IDLE;
            mem_aw_ready    <= 1'b1;
            mem_w_ready     <= 1'b0;
            mem_b_valid     <= 1'b0;
            mem_b_bits_id   <= '0;
            mem_b_bits_resp <= '0;
            w_addr          <= '0;
            w_len           <= '0;
            w_size          <= '0;
            w_burst         <= '0;
            w_cnt           <= '0;
            w_acc           <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (mem_aw_valid && mem_aw_ready) begin
                    mem_b_bits_id <= mem_aw_bits_id;
                    w_addr        <= mem_aw_bits_addr;
                    w_len         <= mem_aw_bits_len;
                    w_size        <= mem_aw_bits_size;
                    w_burst       <= mem_aw_bits_burst;
                    w_cnt         <= '0;
                    w_acc         <= RESP_OKAY;
                    mem_aw_ready  <= 1'b0;
                    mem_w_ready   <= 1'b1;
                    w_state       <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    if (w_final) begin
                        mem_w_ready     <= 1'b0;
                        mem_b_valid     <= 1'b1;
                        mem_b_bits_resp <= w_final_resp;
                        w_state         <= W_RESP;
                    end else begin
                        w_acc  <= w_final_resp;
                        w_cnt  <= w_cnt + 8'd1;
                        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
                    end
                end
                W_RESP: if (mem_b_ready) begin
                    mem_b_valid  <= 1'b0;
                    mem_aw_ready <= 1'b1;
                    w_state      <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, f_addr;
    logic [7:0]            r_len, r_cnt, f_len;
    logic [2:0]            r_size, f_size;
    logic [1:0]            r_burst, f_burst, f_resp;
    logic [DATA_WIDTH-1:0] f_data;

    // Fetch target is beat 0 of the incoming AR in idle, otherwise the next beat.
    always_comb begin
        if (r_state == R_IDLE) begin
            f_addr  = mem_ar_bits_addr;
            f_len   = mem_ar_bits_len;
            f_size  = mem_ar_bits_size;
            f_burst = mem_ar_bits_burst;
        end else begin
            f_addr  = next_addr(r_addr, r_len, r_size, r_burst);
            f_len   = r_len;
            f_size  = r_size;
            f_burst = r_burst;
        end
        f_resp = beat_resp(f_addr, f_len, f_size, f_burst);
        f_data = (f_resp == RESP_OKAY) ? mem[word_idx(f_addr)] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= R_IDLE;
            mem_ar_ready    <= 1'b1;
            mem_r_valid     <= 1'b0;
            mem_r_bits_id   <= '0;
            mem_r_bits_data <= '0;
            mem_r_bits_resp <= '0;
            mem_r_bits_last <= 1'b0;
            r_addr          <= '0;
            r_len           <= '0;
            r_size          <= '0;
            r_burst         <= '0;
            r_cnt           <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (mem_ar_valid && mem_ar_ready) begin
                    r_addr          <= f_addr;
                    r_len           <= mem_ar_bits_len;
                    r_size          <= mem_ar_bits_size;
                    r_burst         <= mem_ar_bits_burst;
                    r_cnt           <= '0;
                    mem_r_bits_id   <= mem_ar_bits_id;
                    mem_r_bits_data <= f_data;
                    mem_r_bits_resp <= f_resp;
                    mem_r_bits_last <= (mem_ar_bits_len == 8'd0);
                    mem_r_valid     <= 1'b1;
                    mem_ar_ready    <= 1'b0;
                    r_state         <= R_DATA;
                end
                R_DATA: if (mem_r_ready) begin
                    if (mem_r_bits_last) begin
                        mem_r_valid  <= 1'b0;
                        mem_ar_ready <= 1'b1;
                        r_state      <= R_IDLE;
                    end else begin
                        r_addr          <= f_addr;
                        r_cnt           <= r_cnt + 8'd1;
                        mem_r_bits_data <= f_data;
                        mem_r_bits_resp <= f_resp;
                        mem_r_bits_last <= (r_cnt + 8'd1 == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed and randomized bursts against a flat-array reference model of the memory.
module tb_axi4_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_aw_valid = 1'b0, mem_aw_ready;
    logic [7:0]  mem_aw_bits_id = '0;
    logic [15:0] mem_aw_bits_addr = '0;
    logic [7:0]  mem_aw_bits_len = '0;
    logic [2:0]  mem_aw_bits_size = '0;
    logic [1:0]  mem_aw_bits_burst = '0;
    logic        mem_w_valid = 1'b0, mem_w_ready;
    logic [31:0] mem_w_bits_data = '0;
    logic [3:0]  mem_w_bits_strb = '0;
    logic        mem_w_bits_last = 1'b0;
    logic        mem_b_valid, mem_b_ready = 1'b0;
    logic [7:0]  mem_b_bits_id;
    logic [1:0]  mem_b_bits_resp;
    logic        mem_ar_valid = 1'b0, mem_ar_ready;
    logic [7:0]  mem_ar_bits_id = '0;
    logic [15:0] mem_ar_bits_addr = '0;
    logic [7:0]  mem_ar_bits_len = '0;
    logic [2:0]  mem_ar_bits_size = '0;
    logic [1:0]  mem_ar_bits_burst = '0;
    logic        mem_r_valid, mem_r_ready = 1'b0;
    logic [7:0]  mem_r_bits_id;
    logic [31:0] mem_r_bits_data;
    logic [1:0]  mem_r_bits_resp;
    logic        mem_r_bits_last;
    logic        side_lock = 1'b0;
    logic [3:0]  side_cache = '0, side_qos = '0;
    logic [2:0]  side_prot = '0;

    always #5 clk = ~clk;

    axi4_mem_responder dut (
        .clk(clk), .rst(rst),
        .mem_aw_valid(mem_aw_valid), .mem_aw_ready(mem_aw_ready),
        .mem_aw_bits_id(mem_aw_bits_id), .mem_aw_bits_addr(mem_aw_bits_addr),
        .mem_aw_bits_len(mem_aw_bits_len), .mem_aw_bits_size(mem_aw_bits_size),
        .mem_aw_bits_burst(mem_aw_bits_burst), .mem_aw_bits_lock(side_lock),
        .mem_aw_bits_cache(side_cache), .mem_aw_bits_prot(side_prot), .mem_aw_bits_qos(side_qos),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready),
        .mem_w_bits_data(mem_w_bits_data), .mem_w_bits_strb(mem_w_bits_strb),
        .mem_w_bits_last(mem_w_bits_last),
        .mem_b_valid(mem_b_valid), .mem_b_ready(mem_b_ready),
        .mem_b_bits_id(mem_b_bits_id), .mem_b_bits_resp(mem_b_bits_resp),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready),
        .mem_ar_bits_id(mem_ar_bits_id), .mem_ar_bits_addr(mem_ar_bits_addr),
        .mem_ar_bits_len(mem_ar_bits_len), .mem_ar_bits_size(mem_ar_bits_size),
        .mem_ar_bits_burst(mem_ar_bits_burst), .mem_ar_bits_lock(side_lock),
        .mem_ar_bits_cache(side_cache), .mem_ar_bits_prot(side_prot), .mem_ar_bits_qos(side_qos),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready),
        .mem_r_bits_id(mem_r_bits_id), .mem_r_bits_data(mem_r_bits_data),
        .mem_r_bits_resp(mem_r_bits_resp), .mem_r_bits_last(mem_r_bits_last)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [31:0] ref_mem [1024];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: beat addresses and responses straight from the burst rules.
    function automatic int unsigned m_addr(input int unsigned a, input int unsigned len,
        input int unsigned size, input int unsigned burst, input int unsigned i);
        int unsigned step, win, base;
        step = 1 << size;
        win  = (len + 1) * step;
        case (burst)
            1: return (a + i * step) & 32'hFFFF;
            2: begin
                base = (a / win) * win;
                return base + ((a - base) + i * step) % win;
            end
            default: return a;
        endcase
    endfunction

    function automatic logic [1:0] m_resp(input int unsigned a, input int unsigned len,
        input int unsigned size, input int unsigned burst);
        logic [1:0] r;
        r = 2'd0;
        if (burst == 3 || size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15}))) r = 2'd2;
        if (a >= 4096) r = 2'd3;
        return r;
    endfunction

    // last_mode: 0 = wlast on final beat only, 1 = never, 2 = every beat
    task automatic m_write(input int unsigned a, input int unsigned len, input int unsigned size,
        input int unsigned burst, input int last_mode, output logic [1:0] br);
        int unsigned ba;
        logic [1:0]  r;
        logic        lb;
        br = 2'd0;
        for (int i = 0; i <= int'(len); i++) begin
            ba = m_addr(a, len, size, burst, i);
            r  = m_resp(ba, len, size, burst);
            if (r > br) br = r;
            lb = (last_mode == 0) ? (i == int'(len)) : (last_mode == 2);
            if (lb != (i == int'(len)) && br < 2'd2) br = 2'd2;
            if (r == 2'd0)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[(ba >> 2) % 1024][8*b +: 8] = wd[i][8*b +: 8];
        end
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        int t;
        t = 0;
        mem_aw_valid = 1'b1; mem_aw_bits_id = id; mem_aw_bits_addr = addr;
        mem_aw_bits_len = len; mem_aw_bits_size = size; mem_aw_bits_burst = burst;
        while (!mem_aw_ready && t < 50) begin @(negedge clk); t++; end
        chk("aw_accept", mem_aw_ready, 1'b1);
        @(negedge clk);
        mem_aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst);
        int t;
        t = 0;
        mem_ar_valid = 1'b1; mem_ar_bits_id = id; mem_ar_bits_addr = addr;
        mem_ar_bits_len = len; mem_ar_bits_size = size; mem_ar_bits_burst = burst;
        while (!mem_ar_ready && t < 50) begin @(negedge clk); t++; end
        chk("ar_accept", mem_ar_ready, 1'b1);
        @(negedge clk);
        mem_ar_valid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
        int t;
        t = 0;
        mem_w_valid = 1'b1; mem_w_bits_data = d; mem_w_bits_strb = s; mem_w_bits_last = l;
        while (!mem_w_ready && t < 50) begin @(negedge clk); t++; end
        chk("w_accept", mem_w_ready, 1'b1);
        @(negedge clk);
        mem_w_valid = 1'b0; mem_w_bits_last = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [7:0] id);
        int t;
        t = 0;
        while (!mem_b_valid && t < 50) begin @(negedge clk); t++; end
        chk("b_arrive", mem_b_valid, 1'b1);
        resp = mem_b_bits_resp; id = mem_b_bits_id;
        mem_b_ready = 1'b1;
        @(negedge clk);
        mem_b_ready = 1'b0;
    endtask

    task automatic axi_write(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst, input int last_mode, input string tag);
        logic [1:0] exp_br, br;
        logic [7:0] bid;
        m_write(addr, len, size, burst, last_mode, exp_br);
        aw_send(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            if ($urandom_range(3) == 0) @(negedge clk);
            w_send(wd[i], ws[i], (last_mode == 0) ? (i == int'(len)) : (last_mode == 2));
        end
        chk({tag, "_bvalid_next"}, mem_b_valid, 1'b1);
        b_recv(br, bid);
        chk({tag, "_bresp"}, br, exp_br);
        chk({tag, "_bid"}, bid, id);
    endtask

    task automatic axi_read(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
        input logic [2:0] size, input logic [1:0] burst, input int hold_beat, input int hold_cyc,
        input string tag);
        int          t;
        int unsigned ba;
        logic [1:0]  er;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        ar_send(id, addr, len, size, burst);
        chk({tag, "_rvalid_next"}, mem_r_valid, 1'b1);
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!mem_r_valid && t < 50) begin @(negedge clk); t++; end
            chk({tag, "_r_arrive"}, mem_r_valid, 1'b1);
            if (i > 0) chk({tag, "_r_back2back"}, t, 0);
            if (i == hold_beat) begin
                mem_r_ready = 1'b0;
                hd = mem_r_bits_data; hr = mem_r_bits_resp; hl = mem_r_bits_last;
                repeat (hold_cyc) begin
                    @(negedge clk);
                    chk({tag, "_hold_valid"}, mem_r_valid, 1'b1);
                    chk({tag, "_hold_data"}, mem_r_bits_data, hd);
                    chk({tag, "_hold_resp"}, mem_r_bits_resp, hr);
                    chk({tag, "_hold_last"}, mem_r_bits_last, hl);
                end
            end
            ba = m_addr(addr, len, size, burst, i);
            er = m_resp(ba, len, size, burst);
            rd_data[i] = mem_r_bits_data;
            rd_resp[i] = mem_r_bits_resp;
            chk({tag, "_rdata"}, mem_r_bits_data, (er == 2'd0) ? ref_mem[(ba >> 2) % 1024] : 32'd0);
            chk({tag, "_rresp"}, mem_r_bits_resp, er);
            chk({tag, "_rlast"}, mem_r_bits_last, i == int'(len));
            chk({tag, "_rid"}, mem_r_bits_id, id);
            mem_r_ready = 1'b1;
            @(negedge clk);
        end
        mem_r_ready = 1'b0;
        chk({tag, "_arready_back"}, mem_ar_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [1:0]  br;
        logic [7:0]  bid;
        logic [1:0]  rb;
        logic [2:0]  rs;
        logic [7:0]  rl;
        logic [15:0] ra;
        logic [31:0] old_rst [8];

        for (int k = 0; k < 1024; k++) ref_mem[k] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bvalid", mem_b_valid, 1'b0);
        chk("rst_rvalid", mem_r_valid, 1'b0);
        chk("rst_wready", mem_w_ready, 1'b0);
        chk("rst_rdata", mem_r_bits_data, 32'd0);
        chk("rst_rlast", mem_r_bits_last, 1'b0);
        chk("rst_bresp", mem_b_bits_resp, 2'd0);
        chk("rst_rid", mem_r_bits_id, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_awready", mem_aw_ready, 1'b1);
        chk("post_rst_arready", mem_ar_ready, 1'b1);

        // Zero the region used below
        for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 4'hF; end
        for (int k = 0; k < 16; k++) axi_write(8'd0, 16'(k * 64), 8'd15, 3'd2, 2'd1, 0, "init");

        // Write then read
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        axi_write(8'h5A, 16'h0010, 8'd3, 3'd2, 2'd1, 0, "wr1");
        axi_read(8'h5A, 16'h0010, 8'd3, 3'd2, 2'd1, -1, 0, "rd1");
        chk("rd1_beat3_const", rd_data[3], 32'h44444444);

        // Strobes
        wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
        axi_write(8'h01, 16'h0040, 8'd0, 3'd2, 2'd1, 0, "strb");
        axi_read(8'h01, 16'h0040, 8'd0, 3'd2, 2'd1, -1, 0, "strb_rd");
        chk("strb_const", rd_data[0], 32'h00BB00DD);
        ws[0] = 4'hF;

        // Out-of-range read and reserved burst
        axi_read(8'h02, 16'h1000, 8'd0, 3'd2, 2'd1, -1, 0, "oor");
        chk("oor_resp_const", rd_resp[0], 2'd3);
        wd[0] = 32'hDEADBEEF;
        axi_write(8'h03, 16'h0010, 8'd0, 3'd2, 2'd3, 0, "rsvd");
        axi_read(8'h03, 16'h0010, 8'd0, 3'd2, 2'd1, -1, 0, "rsvd_rd");
        chk("rsvd_unchanged", rd_data[0], 32'h11111111);

        // WRAP with backpressure on beat 1
        axi_read(8'h04, 16'h0018, 8'd3, 3'd2, 2'd2, 1, 3, "wrap");
        chk("wrap_b0", rd_data[0], 32'h33333333);
        chk("wrap_b1", rd_data[1], 32'h44444444);
        chk("wrap_b2", rd_data[2], 32'h11111111);
        chk("wrap_b3", rd_data[3], 32'h22222222);

        // wlast protocol errors
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002;
        axi_write(8'h06, 16'h0080, 8'd1, 3'd2, 2'd1, 1, "nolast");
        axi_read(8'h06, 16'h0080, 8'd1, 3'd2, 2'd1, -1, 0, "nolast_rd");
        wd[0] = 32'hBEEF0001; wd[1] = 32'hBEEF0002;
        axi_write(8'h07, 16'h0090, 8'd1, 3'd2, 2'd1, 2, "earlylast");

        // Same-cycle read fetch and write of one word
        wd[0] = 32'h0BAD0001;
        axi_write(8'h08, 16'h0100, 8'd0, 3'd2, 2'd1, 0, "cc_pre");
        aw_send(8'h09, 16'h0100, 8'd0, 3'd2, 2'd1);
        mem_ar_valid = 1'b1; mem_ar_bits_id = 8'h09; mem_ar_bits_addr = 16'h0100;
        mem_ar_bits_len = 8'd0; mem_ar_bits_size = 3'd2; mem_ar_bits_burst = 2'd1;
        mem_w_valid = 1'b1; mem_w_bits_data = 32'h600D0002; mem_w_bits_strb = 4'hF;
        mem_w_bits_last = 1'b1;
        chk("cc_arready", mem_ar_ready, 1'b1);
        chk("cc_wready", mem_w_ready, 1'b1);
        @(negedge clk);
        mem_ar_valid = 1'b0; mem_w_valid = 1'b0; mem_w_bits_last = 1'b0;
        chk("cc_rvalid", mem_r_valid, 1'b1);
        chk("cc_old_value", mem_r_bits_data, 32'h0BAD0001);
        mem_r_ready = 1'b1;
        @(negedge clk);
        mem_r_ready = 1'b0;
        b_recv(br, bid);
        chk("cc_bresp", br, 2'd0);
        ref_mem[16'h0100 >> 2] = 32'h600D0002;
        axi_read(8'h0A, 16'h0100, 8'd0, 3'd2, 2'd1, -1, 0, "cc_new");

        // Reset during beat 2 of a len-7 write
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        axi_write(8'h0B, 16'h0200, 8'd7, 3'd2, 2'd1, 0, "rst_pre");
        for (int i = 0; i < 8; i++) begin old_rst[i] = wd[i]; wd[i] = $urandom; end
        aw_send(8'h0C, 16'h0200, 8'd7, 3'd2, 2'd1);
        w_send(wd[0], 4'hF, 1'b0);
        w_send(wd[1], 4'hF, 1'b0);
        mem_w_valid = 1'b1; mem_w_bits_data = wd[2]; mem_w_bits_strb = 4'hF;
        rst = 1'b0;
        @(negedge clk);
        mem_w_valid = 1'b0;
        chk("midrst_bvalid_in_rst", mem_b_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_awready", mem_aw_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("midrst_bvalid_after", mem_b_valid, 1'b0);
        ref_mem[16'h0200 >> 2]       = wd[0];
        ref_mem[(16'h0200 >> 2) + 1] = wd[1];
        axi_read(8'h0D, 16'h0200, 8'd7, 3'd2, 2'd1, -1, 0, "midrst_rd");
        chk("midrst_beat1", rd_data[1], wd[1]);
        chk("midrst_beat2_old", rd_data[2], old_rst[2]);

        // Randomized bursts inside the zeroed region
        for (int it = 0; it < 12; it++) begin
            rb = 2'($urandom_range(2));
            rs = 3'($urandom_range(2));
            if (rb == 2'd2) rl = 8'((2 << $urandom_range(3)) - 1);
            else            rl = 8'($urandom_range(15));
            ra = 16'($urandom_range(16'h03BF)) & ~16'((1 << rs) - 1);
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            axi_write(8'($urandom), ra, rl, rs, rb, 0, "rnd_wr");
            axi_read(8'($urandom), ra, rl, rs, rb, $urandom_range(int'(rl)),
                     $urandom_range(3), "rnd_rd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/axi4_mem_responder.md
Name: axi4_mem_responder

Overview:
- AXI4 slave memory model that terminates the accelerator's outbound mem_* master port. It sits directly downstream of the DummyRRM shell top.
- Backs the port with a word-addressed register array and serves independent read and write channels, each with one outstanding burst.
- Used in simulation and on FPGA bring-up builds where no external DDR controller is present.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (power of two, >= 8).
- ADDR_WIDTH, 16, byte address width.
- ID_WIDTH, 8, AXI ID width.
- DEPTH_WORDS, 1024, number of DATA_WIDTH words stored (power of two).
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_aw_valid/ready  in/out  1/1  write address handshake.
- mem_aw_bits_id  in  ID_WIDTH  write ID.
- mem_aw_bits_addr  in  ADDR_WIDTH  start byte address.
- mem_aw_bits_len  in  8  beats minus one.
- mem_aw_bits_size  in  3  log2 bytes per beat.
- mem_aw_bits_burst  in  2  FIXED=0, INCR=1, WRAP=2.
- mem_aw_bits_lock/cache/prot/qos  in  1/4/3/4  ignored.
- mem_w_valid/ready  in/out  1/1  write data handshake.
- mem_w_bits_data  in  DATA_WIDTH  write data.
- mem_w_bits_strb  in  STRB_WIDTH  byte enables.
- mem_w_bits_last  in  1  last beat marker.
- mem_b_valid/ready  out/in  1/1  write response handshake.
- mem_b_bits_id  out  ID_WIDTH  echoed AW ID.
- mem_b_bits_resp  out  2  write response.
- mem_ar_valid/ready  in/out  1/1  read address handshake.
- mem_ar_bits_id/addr/len/size/burst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  same meaning as AW.
- mem_ar_bits_lock/cache/prot/qos  in  1/4/3/4  ignored.
- mem_r_valid/ready  out/in  1/1  read data handshake.
- mem_r_bits_id  out  ID_WIDTH  echoed AR ID.
- mem_r_bits_data  out  DATA_WIDTH  read data.
- mem_r_bits_resp  out  2  read response.
- mem_r_bits_last  out  1  last beat marker.

Behaviour:
- Reset (rst=0, async): both FSMs go to IDLE. All valid outputs are 0; all data/id/resp outputs are 0. awready=1 and arready=1 once rst deasserts. Array contents are not reset.
- Word index = (beat_addr >> log2(STRB_WIDTH)) mod DEPTH_WORDS. A beat is out of range when beat_addr >= DEPTH_WORDS*STRB_WIDTH.
- Beat address progression:
  - FIXED: address constant across the burst.
  - INCR: address += 2^size per beat.
  - WRAP: address wraps within an aligned window of (len+1)*2^size bytes; len must be 1, 3, 7 or 15, otherwise the burst gets SLVERR.
  - Burst 3 (reserved) or size > log2(STRB_WIDTH): SLVERR on every beat, no array write.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: awready=1. The AW handshake latches id, addr, len, size and burst, clears the beat counter, and moves to W_DATA.
  - W_DATA: wready=1. Each w handshake writes the strobed bytes in the same cycle, except for error beats.
  - The beat counter reaching len ends the burst regardless of wlast. If wlast is asserted on a non-final beat, or absent on the final beat, bresp=SLVERR.
  - W_RESP: bvalid=1 the cycle after the final W beat. bresp = highest code seen (OKAY 0 < SLVERR 2 < DECERR 3, so DECERR wins). The B handshake returns the FSM to W_IDLE.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: arready=1. The AR handshake latches the burst and moves to R_DATA.
  - R_DATA: rvalid rises the cycle after the AR handshake with registered data for beat 0. Each rvalid&rready advances to the next beat; with rready held high, one beat is delivered per cycle.
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - rlast=1 on beat len. rresp is per beat; out-of-range beats return DECERR with data 0.
  - A handshake on the last beat returns the FSM to R_IDLE. The next AR is accepted in that R_IDLE cycle, not the same cycle.
- Channels are fully independent; a read and a write may proceed concurrently.
- Same-cycle read fetch and write to the same word: the read returns the pre-write value.
- Back-to-back writes: awready is 0 during W_DATA and W_RESP, so a new AW is accepted only in W_IDLE.
- Reset mid-burst: both FSMs abort to IDLE immediately with no response issued. Beats already written remain in the array.

Test Plan:
- Write then read: AW addr 0x0010, len 3, size 2, INCR, id 0x5A; W data 0x11111111..0x44444444 with strb 0xF, wlast on beat 3 -> bresp 0, bid 0x5A. AR with the same fields -> four R beats with that data, rlast only on beat 3, rresp 0.
- Strobes: write 0xAABBCCDD with strb 0x5 at 0x0040 over a word previously all-zero -> read returns 0x00BB00DD.
- Error responses:
  - AR at 0x1000 (= DEPTH*4), len 0 -> rresp 3, rdata 0, rlast 1.
  - AW burst 3 -> bresp 2, memory unchanged.
- Wrap and backpressure: WRAP read at 0x0018, len 3, size 2 -> beat addresses 0x18, 0x1C, 0x10, 0x14. With rready low 3 cycles on beat 1, the R outputs stay stable.
- Protocol and concurrency:
  - wlast missing on the final beat of a len-1 write -> bresp 2, two beats written.
  - Concurrent read and write to the same word in the same cycle -> the read returns the old value.
- Reset mid-burst: assert rst during beat 2 of a len-7 write -> bvalid stays 0, awready=1 after release. Beats 0-1 are readable; beats 2-7 are unchanged.
